// File: rtl/meteo_display_ctrl_pkg.sv
// Shared types and seven-segment constants for the meteo display controller.
package meteo_display_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/meteo_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock, W iterations per start.
module bin2bcd_seq #(
    parameter int W    = 32,
    parameter int NDIG = 6
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              start_i,
    input  logic [W-1:0]      mag_i,
    output logic [4*NDIG-1:0] bcd_o,
    output logic              ovf_o,
    output logic              done_o
);

    localparam int BW    = 4 * NDIG;
    localparam int CNT_W = $clog2(W + 1);

    logic [BW-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [W-1:0]     mag_q, mag_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bcd_q <= '0;
            mag_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            bcd_q <= bcd_d;
            mag_q <= mag_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        bcd_d = bcd_q;
        mag_d = mag_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (start_i) begin
            bcd_d = '0;
            mag_d = mag_i;
            ovf_d = 1'b0;
            cnt_d = CNT_W'(W);
        end else if (cnt_q != '0) begin
            // A carry out of the top nibble means the value no longer fits in NDIG digits
            bcd_d = {bcd_adj[BW-2:0], mag_q[W-1]};
            mag_d = {mag_q[W-2:0], 1'b0};
            ovf_d = ovf_q | bcd_adj[BW-1];
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;
    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/meteo_display_ctrl.sv
// Multi-channel 7-segment display controller: snapshot, channel select/auto-rotate,
// request flag, conversion sequencing and digit mapping.
//
//   state  | meaning
//   IDLE   | waiting for a display request
//   LOAD   | latch magnitude/sign of the selected channel, clear converter
//   SHIFT  | W double-dabble iterations running
//   DONE   | map BCD to segments, update Dec_o / Ovf_o
module meteo_display_ctrl
    import meteo_display_ctrl_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int W      = 32,
    parameter int NDIG   = 6,
    parameter int PERIOD = 100_000_000,
    parameter int CW     = $clog2(NCH)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NCH*W-1:0]  Values_i,
    input  logic [NCH-1:0]    Signed_i,
    input  logic              Update_i,
    input  logic [CW-1:0]     Sel_i,
    input  logic              Auto_i,
    input  logic              Blank_i,
    output logic [NDIG*7-1:0] Dec_o,
    output logic [CW-1:0]     Chan_o,
    output logic              Busy_o,
    output logic              Ovf_o
);

    localparam int BW      = 4 * NDIG;
    localparam int DWELL_W = $clog2(PERIOD);

    state_e             state_q, state_d;
    logic [W-1:0]       snap_q [NCH];
    logic [CW-1:0]      chan_q, chan_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               auto_q;
    logic               req_q, req_d;
    logic               neg_q, neg_d;
    logic [NDIG*7-1:0]  dec_q, dec_d;
    logic               ovf_q, ovf_d;

    logic               trig, pending;
    logic               busy, start, done_en, conv_done, conv_ovf;
    logic [W-1:0]       cur_val, mag;
    logic               neg_now;
    logic [BW-1:0]      bcd;
    logic               lead;
    logic [3:0]         nib;
    logic [6:0]         seg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int c = 0; c < NCH; c++) snap_q[c] <= '0;
        end else if (Update_i) begin
            for (int c = 0; c < NCH; c++) snap_q[c] <= Values_i[c*W +: W];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            chan_q  <= '0;
            dwell_q <= '0;
            auto_q  <= 1'b0;
            req_q   <= 1'b0;
            neg_q   <= 1'b0;
            dec_q   <= {NDIG{SEG_BLANK}};
            ovf_q   <= 1'b0;
        end else begin
            chan_q  <= chan_d;
            dwell_q <= dwell_d;
            auto_q  <= Auto_i;
            req_q   <= req_d;
            neg_q   <= neg_d;
            dec_q   <= dec_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entering auto mode restarts the dwell without moving the channel
    always_comb begin
        chan_d  = chan_q;
        dwell_d = dwell_q;
        if (Auto_i) begin
            if (!auto_q) begin
                dwell_d = '0;
            end else if (dwell_q == DWELL_W'(PERIOD - 1)) begin
                dwell_d = '0;
                chan_d  = (chan_q == CW'(NCH - 1)) ? '0 : chan_q + CW'(1);
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end else begin
            dwell_d = '0;
            if (Sel_i <= CW'(NCH - 1)) chan_d = Sel_i;
        end
    end

    assign trig    = Update_i | (chan_d != chan_q);
    assign pending = req_q | trig;

    always_comb begin
        req_d = req_q | trig;
        if (state_q == ST_IDLE && pending) req_d = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pending) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (conv_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b1;
        start   = 1'b0;
        done_en = 1'b0;
        case (state_q)
            ST_IDLE: busy    = 1'b0;
            ST_LOAD: start   = 1'b1;
            ST_DONE: done_en = 1'b1;
            default: ;
        endcase
    end

    assign cur_val = snap_q[chan_q];
    assign neg_now = Signed_i[chan_q] & cur_val[W-1];
    assign mag     = neg_now ? -cur_val : cur_val;
    assign neg_d   = start ? neg_now : neg_q;

    bin2bcd_seq #(
        .W    (W),
        .NDIG (NDIG)
    ) u_bin2bcd (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .start_i (start),
        .mag_i   (mag),
        .bcd_o   (bcd),
        .ovf_o   (conv_ovf),
        .done_o  (conv_done)
    );

    always_comb begin
        dec_d = dec_q;
        ovf_d = ovf_q;
        lead  = 1'b1;
        nib   = '0;
        seg   = SEG_BLANK;
        if (done_en) begin
            // The sign needs the top digit, so a negative value may use only NDIG-1 digits
            if (conv_ovf || (neg_q && bcd[BW-1 -: 4] != 4'd0)) begin
                dec_d = {NDIG{SEG_MINUS}};
                ovf_d = 1'b1;
            end else begin
                ovf_d = 1'b0;
                for (int d = NDIG - 1; d >= 0; d--) begin
                    nib = bcd[4*d +: 4];
                    if (nib != 4'd0) lead = 1'b0;
                    if (Blank_i && lead && d != 0) seg = SEG_BLANK;
                    else                           seg = seg_encode(nib);
                    if (neg_q && d == NDIG - 1) seg = SEG_MINUS;
                    dec_d[7*d +: 7] = seg;
                end
            end
        end
    end

    assign Dec_o  = dec_q;
    assign Chan_o = chan_q;
    assign Busy_o = busy;
    assign Ovf_o  = ovf_q;

endmodule
